// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared encodings and helpers for the memory controller slice:
//            FSM state codes, access size codes, requester IDs, the mapping
//            from size code to last byte index, and the IO-region predicate.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Controller FSM states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;

    // Access size codes as presented by the LSB (3 behaves as word)
    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

    // Requester identifiers
    localparam logic c_req_if = 1'b0;
    localparam logic c_req_ls = 1'b1;

    // Index of the final byte of an access (byte count minus one)
    function automatic logic [1:0] size_last(input logic [1:0] size);
        logic [1:0] last;
        case (size)
            c_size_byte: last = 2'd0;
            c_size_half: last = 2'd1;
            default:     last = 2'd3;
        endcase
        return last;
    endfunction

    // True when every bit of addr[hi:lo] is set
    function automatic logic addr_is_io(input logic [63:0] addr,
                                        input int          hi,
                                        input int          lo);
        logic io;
        io = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i >= lo && i <= hi && !addr[i]) begin
                io = 1'b0;
            end
        end
        return io;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Purpose  : Two-way round-robin pick between instruction fetch and the LSB.
//            When both request, the one not granted last time wins.
// Ports    : clk_in, rst_in     - clock, async active-high reset
//            grant_en           - a grant may be issued this edge
//            if_req, ls_req     - request levels
//            grant_if, grant_ls - one-hot grant (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic grant_en,
    input  logic if_req,
    input  logic ls_req,
    output logic grant_if,
    output logic grant_ls
);

    logic r_last_grant;

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (grant_en) begin
            if (if_req && ls_req) begin
                if (r_last_grant == c_req_if) begin
                    grant_ls = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else begin
                grant_if = if_req;
                grant_ls = ls_req;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_last_grant <= c_req_if;
        end else if (grant_if) begin
            r_last_grant <= c_req_if;
        end else if (grant_ls) begin
            r_last_grant <= c_req_ls;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Single-port memory controller. Arbitrates fetch and LSB requests
//            round-robin, serialises 1/2/4-byte accesses into byte-wide bus
//            cycles and reassembles read data little-endian.
// Ports    : clk_in, rst_in, rdy_in       - clock, async reset, global ready
//            rob_clear_up                 - pipeline flush
//            if_req/if_addr/if_ready/if_data           - fetch port
//            ls_req/ls_wr/ls_size/ls_addr/ls_wdata/
//            ls_ready/ls_rdata                         - LSB port
//            mem_din/mem_dout/mem_a/mem_wr             - RAM/IO byte bus
//            io_buffer_full               - UART buffer full (write stall)
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17,
    parameter int IO_SEL_LO = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear_up,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;      // byte index currently on the bus
    logic [1:0]        r_last;     // index of the final byte
    logic              r_req_id;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;      // read bytes gathered so far
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic              r_mem_wr;
    logic              r_if_ready;
    logic [31:0]       r_if_data;
    logic              r_ls_ready;
    logic [31:0]       r_ls_rdata;

    logic              w_grant_en;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_wr;
    logic [1:0]        w_sel_last;
    logic [31:0]       w_rd_word;
    logic [1:0]        w_wr_idx;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_wr_stall;
    logic              w_grant_stall;

    // The ready terms act as a one-cycle cooldown so a request level that is
    // still high from the previous transaction is not granted a second time.
    assign w_grant_en = rdy_in && (r_state == c_st_idle) && !r_if_ready &&
                        !r_ls_ready && !rob_clear_up;

    mem_rr_arbiter u_arb (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .grant_en (w_grant_en),
        .if_req   (if_req),
        .ls_req   (ls_req),
        .grant_if (w_grant_if),
        .grant_ls (w_grant_ls)
    );

    assign w_sel_addr    = w_grant_ls ? ls_addr : if_addr;
    assign w_sel_wr      = w_grant_ls && ls_wr;
    assign w_sel_last    = w_grant_ls ? size_last(ls_size) : 2'd3;
    assign w_grant_stall = addr_is_io(64'(w_sel_addr), IO_SEL_HI, IO_SEL_LO) &&
                           io_buffer_full;

    // Read data with the byte now arriving on mem_din merged in
    always_comb begin
        w_rd_word = r_buf;
        w_rd_word[{r_cnt, 3'b000} +: 8] = mem_din;
    end

    // A byte that was actually driven with mem_wr advances the index; a
    // stalled byte is retried at the same index.
    assign w_wr_idx   = r_mem_wr ? (r_cnt + 2'd1) : r_cnt;
    assign w_wr_addr  = r_addr + ADDR_W'(w_wr_idx);
    assign w_wr_stall = addr_is_io(64'(w_wr_addr), IO_SEL_HI, IO_SEL_LO) &&
                        io_buffer_full;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= c_st_idle;
            r_cnt      <= 2'd0;
            r_last     <= 2'd0;
            r_req_id   <= c_req_if;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_ready <= 1'b0;
            r_if_data  <= '0;
            r_ls_ready <= 1'b0;
            r_ls_rdata <= '0;
        end else if (rdy_in) begin
            r_if_ready <= 1'b0;
            r_ls_ready <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_mem_wr <= 1'b0;
                    if (w_grant_if || w_grant_ls) begin
                        r_addr   <= w_sel_addr;
                        r_last   <= w_sel_last;
                        r_req_id <= w_grant_ls ? c_req_ls : c_req_if;
                        r_wdata  <= ls_wdata;
                        r_cnt    <= 2'd0;
                        r_buf    <= '0;
                        r_mem_a  <= w_sel_addr;
                        if (w_sel_wr) begin
                            r_state    <= c_st_write;
                            r_mem_dout <= ls_wdata[7:0];
                            r_mem_wr   <= !w_grant_stall;
                        end else begin
                            r_state <= c_st_read;
                        end
                    end
                end
                c_st_read: begin
                    if (rob_clear_up) begin
                        // Speculative read abandoned; no ready pulse
                        r_state <= c_st_idle;
                        r_cnt   <= 2'd0;
                    end else if (r_cnt == r_last) begin
                        r_state <= c_st_idle;
                        r_cnt   <= 2'd0;
                        if (r_req_id == c_req_if) begin
                            r_if_data  <= w_rd_word;
                            r_if_ready <= 1'b1;
                        end else begin
                            r_ls_rdata <= w_rd_word;
                            r_ls_ready <= 1'b1;
                        end
                    end else begin
                        r_buf   <= w_rd_word;
                        r_cnt   <= r_cnt + 2'd1;
                        r_mem_a <= r_addr + ADDR_W'(r_cnt + 2'd1);
                    end
                end
                c_st_write: begin
                    // Flush is ignored here: the store is already committed.
                    if (r_mem_wr && (r_cnt == r_last)) begin
                        r_mem_wr   <= 1'b0;
                        r_ls_ready <= 1'b1;
                        r_state    <= c_st_idle;
                        r_cnt      <= 2'd0;
                    end else begin
                        r_cnt      <= w_wr_idx;
                        r_mem_a    <= w_wr_addr;
                        r_mem_dout <= r_wdata[{w_wr_idx, 3'b000} +: 8];
                        r_mem_wr   <= !w_wr_stall;
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_cnt    <= 2'd0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign if_ready = r_if_ready;
    assign if_data  = r_if_data;
    assign ls_ready = r_ls_ready;
    assign ls_rdata = r_ls_rdata;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    // Gated so nothing is written to RAM while the block is frozen
    assign mem_wr   = r_mem_wr && rdy_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a byte RAM model
//            (combinational read of mem_a) and an IO write log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_up;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:1023];
    int          io_cnt;
    logic [7:0]  io_last;

    int total = 0;
    int bad   = 0;

    mem_ctrl #(
        .ADDR_W    (32),
        .IO_SEL_HI (17),
        .IO_SEL_LO (16)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear_up   (rob_clear_up),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ready       (if_ready),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_wr          (ls_wr),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_ready       (ls_ready),
        .ls_rdata       (ls_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM: read byte is the content at the currently registered address, so
    // byte k addressed at edge E_k is captured by the controller at E_{k+1}.
    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            ram[10'h100] <= 8'h13;
            ram[10'h200] <= 8'h11;
            ram[10'h201] <= 8'h22;
            ram[10'h202] <= 8'h33;
            ram[10'h203] <= 8'h44;
            ram[10'h206] <= 8'h5A;
            io_cnt       <= 0;
            io_last      <= 8'h00;
        end else if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) begin
                io_cnt  <= io_cnt + 1;
                io_last <= mem_dout;
            end else begin
                ram[mem_a[9:0]] <= mem_dout;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ls(output int n);
        n = 0;
        while (ls_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
        io_buffer_full = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_ls_ready", 32'(ls_ready), 32'd0);
        chk("rst_mem_wr",   32'(mem_wr),   32'd0);
        chk("rst_mem_a",    mem_a,         32'd0);
        chk("rst_if_data",  if_data,       32'd0);
        chk("rst_ls_rdata", ls_rdata,      32'd0);
        rst_in = 1'b0;

        // 1. Fetch word @0x100
        if_req = 1'b1; if_addr = 32'h100;
        tick(); chk("t1_a0", mem_a, 32'h100); chk("t1_wr", 32'(mem_wr), 32'd0);
        tick(); chk("t1_a1", mem_a, 32'h101);
        tick(); chk("t1_a2", mem_a, 32'h102);
        tick(); chk("t1_a3", mem_a, 32'h103); chk("t1_rdy_early", 32'(if_ready), 32'd0);
        tick(); chk("t1_rdy", 32'(if_ready), 32'd1); chk("t1_data", if_data, 32'h13);
        if_req = 1'b0;
        tick(); chk("t1_rdy_fall", 32'(if_ready), 32'd0);

        // 2. Contention: last grant was IF, so LS wins first
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
        tick(); chk("t2_ls_first", mem_a, 32'h200);
        tick(); tick(); tick();
        chk("t2_ls_rdy_early", 32'(ls_ready), 32'd0);
        tick(); chk("t2_ls_rdy", 32'(ls_ready), 32'd1);
        chk("t2_ls_data", ls_rdata, 32'h44332211);
        chk("t2_if_rdy_none", 32'(if_ready), 32'd0);
        ls_req = 1'b0;
        tick(); chk("t2_ls_fall", 32'(ls_ready), 32'd0); chk("t2_cooldown", mem_a, 32'h203);
        tick(); chk("t2_if_grant", mem_a, 32'h100);
        tick(); tick(); tick(); tick();
        chk("t2_if_rdy", 32'(if_ready), 32'd1); chk("t2_if_data", if_data, 32'h13);
        chk("t2_ls_single", 32'(ls_ready), 32'd0);
        if_req = 1'b0;
        tick(); chk("t2_if_fall", 32'(if_ready), 32'd0);

        // 3. Store half 0x1234BEEF @0x204
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h204; ls_wdata = 32'h1234BEEF;
        tick(); chk("t3_wr0", 32'(mem_wr), 32'd1); chk("t3_a0", mem_a, 32'h204); chk("t3_d0", 32'(mem_dout), 32'hEF);
        tick(); chk("t3_wr1", 32'(mem_wr), 32'd1); chk("t3_a1", mem_a, 32'h205); chk("t3_d1", 32'(mem_dout), 32'hBE);
        tick(); chk("t3_wr_end", 32'(mem_wr), 32'd0); chk("t3_rdy", 32'(ls_ready), 32'd1);
        ls_req = 1'b0;
        chk("t3_ram204", 32'(ram[10'h204]), 32'hEF);
        chk("t3_ram205", 32'(ram[10'h205]), 32'hBE);
        chk("t3_ram206", 32'(ram[10'h206]), 32'h5A);
        tick(); chk("t3_rdy_fall", 32'(ls_ready), 32'd0);

        // 4. IO store with buffer full for three edges
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
        io_buffer_full = 1'b1;
        tick(); chk("t4_stall0", 32'(mem_wr), 32'd0); chk("t4_a", mem_a, 32'h30000);
        tick(); chk("t4_stall1", 32'(mem_wr), 32'd0);
        tick(); chk("t4_stall2", 32'(mem_wr), 32'd0);
        io_buffer_full = 1'b0;
        tick(); chk("t4_wr", 32'(mem_wr), 32'd1); chk("t4_d", 32'(mem_dout), 32'h41);
        tick(); chk("t4_wr_end", 32'(mem_wr), 32'd0); chk("t4_rdy", 32'(ls_ready), 32'd1);
        chk("t4_io_cnt", 32'(io_cnt), 32'd1); chk("t4_io_byte", 32'(io_last), 32'h41);
        ls_req = 1'b0;
        tick();

        // 5a. Flush during fetch byte 2
        if_req = 1'b1; if_addr = 32'h100;
        tick(); tick(); tick(); chk("t5a_a2", mem_a, 32'h102);
        rob_clear_up = 1'b1; if_req = 1'b0;
        tick(); chk("t5a_no_rdy", 32'(if_ready), 32'd0); chk("t5a_abort", mem_a, 32'h102);
        rob_clear_up = 1'b0;
        tick(); chk("t5a_no_rdy2", 32'(if_ready), 32'd0); chk("t5a_idle", mem_a, 32'h102);

        // 5b. Flush during a store is ignored
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'hA1B2C3D4;
        tick();
        rob_clear_up = 1'b1;
        tick(); tick();
        rob_clear_up = 1'b0;
        wait_ls(n);
        chk("t5b_lat", 32'(n), 32'd2);
        chk("t5b_ram0", 32'(ram[10'h300]), 32'hD4);
        chk("t5b_ram3", 32'(ram[10'h303]), 32'hA1);
        ls_req = 1'b0;
        tick();

        // Flush in IDLE blocks the grant; then a byte load zero-extends
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h201;
        rob_clear_up = 1'b1;
        tick(); chk("t5c_no_grant", mem_a, 32'h303);
        rob_clear_up = 1'b0;
        tick(); chk("t5c_grant", mem_a, 32'h201);
        tick(); chk("t5c_rdy", 32'(ls_ready), 32'd1); chk("t5c_data", ls_rdata, 32'h22);
        ls_req = 1'b0;
        tick();

        // 6a. Asynchronous reset mid-read
        if_req = 1'b1; if_addr = 32'h100;
        tick(); tick(); chk("t6a_a1", mem_a, 32'h101);
        #2 rst_in = 1'b1;
        #1 chk("t6a_a_rst", mem_a, 32'd0);
        chk("t6a_rdy_rst", 32'(if_ready), 32'd0);
        chk("t6a_wr_rst", 32'(mem_wr), 32'd0);
        if_req = 1'b0;
        tick();
        rst_in = 1'b0;

        // 6b. Freeze mid-store, then resume at the same byte
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h310; ls_wdata = 32'h55667788;
        tick(); chk("t6b_a0", mem_a, 32'h310); chk("t6b_d0", 32'(mem_dout), 32'h88);
        tick(); chk("t6b_a1", mem_a, 32'h311);
        rdy_in = 1'b0;
        #1 chk("t6b_gated", 32'(mem_wr), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("t6b_frozen_wr", 32'(mem_wr), 32'd0);
        chk("t6b_frozen_a", mem_a, 32'h311);
        chk("t6b_ram_hold", 32'(ram[10'h311]), 32'h00);
        rdy_in = 1'b1;
        #1 chk("t6b_resume_wr", 32'(mem_wr), 32'd1);
        chk("t6b_resume_d", 32'(mem_dout), 32'h77);
        wait_ls(n);
        chk("t6b_lat", 32'(n), 32'd3);
        chk("t6b_ram0", 32'(ram[10'h310]), 32'h88);
        chk("t6b_ram1", 32'(ram[10'h311]), 32'h77);
        chk("t6b_ram2", 32'(ram[10'h312]), 32'h66);
        chk("t6b_ram3", 32'(ram[10'h313]), 32'h55);
        ls_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
